// File: rtl/cnt_wrap_monitor.sv
// Step/wrap monitor for an upstream free-running counter: flags step errors, detects wraps
// and queues wrap-to-wrap periods in a small FIFO. Define CNT_MON_HOLD_EN to treat a held value as a stall.
module cnt_wrap_monitor #(
    parameter int CW         = 8,
    parameter int INC_DEC    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] cnt_i,
    output logic          wrap_o,
    output logic          err_o,
    output logic [7:0]    err_cnt_o,
    output logic [PW-1:0] per_data_o,
    output logic          per_valid_o,
    input  logic          per_ready_i,
    output logic          per_ovf_o
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] PER_ONE = PW'(1);
    localparam logic [PW-1:0] PER_MAX = '1;
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TRACK
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_prev;
    logic          r_armed;
    logic [PW-1:0] r_per;
    logic          r_wrap;
    logic          r_err;
    logic [7:0]    r_err_cnt;
    logic          r_ovf;

    logic [PW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;

    logic [CW-1:0]         w_exp;
    logic                  w_track;
    logic                  w_stall;
    logic                  w_step_ok;
    logic                  w_step_err;
    logic                  w_wrap_det;
    logic                  w_push_req;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [FIFO_DEPTH-1:0] w_we;

    assign w_exp   = (INC_DEC != 0) ? (r_prev + CNT_ONE) : (r_prev - CNT_ONE);
    assign w_track = en_i && (r_state == ST_TRACK);

`ifdef CNT_MON_HOLD_EN
    assign w_stall = w_track && (cnt_i == r_prev);
`else
    assign w_stall = 1'b0;
`endif

    assign w_step_ok  = w_track && !w_stall && (cnt_i == w_exp);
    assign w_step_err = w_track && !w_stall && (cnt_i != w_exp);
    assign w_wrap_det = w_step_ok && ((INC_DEC != 0) ? (r_prev == CNT_MAX) : (r_prev == '0));
    // The first wrap after a (re)sync only marks the reference point; later wraps carry a period.
    assign w_push_req = w_wrap_det && r_armed;

    always_comb begin
        w_state_next = r_state;
        if (!en_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_SYNC;
                ST_SYNC:  w_state_next = ST_TRACK;
                ST_TRACK: w_state_next = w_step_err ? ST_SYNC : ST_TRACK;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_armed   <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else begin
            r_wrap <= w_wrap_det;
            if (!en_i) begin
                r_armed <= 1'b0;
            end else begin
                if (r_state == ST_SYNC || w_step_ok) begin
                    r_prev <= cnt_i;
                end
                if (w_step_err) begin
                    r_err   <= 1'b1;
                    r_armed <= 1'b0;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end else if (w_wrap_det) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    // Holds the number of TRACK cycles since the last wrap edge, so at a wrap edge it is the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per <= '0;
        end else if (w_wrap_det) begin
            r_per <= PER_ONE;
        end else if (w_track && r_per != PER_MAX) begin
            r_per <= r_per + PER_ONE;
        end
    end

    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == FILL_MAX);
    assign w_pop   = !w_empty && per_ready_i;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_push && (r_wr_ptr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_we[i]) begin
                r_mem[i] <= r_per;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FILL_ONE;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - FILL_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign wrap_o      = r_wrap;
    assign err_o       = r_err;
    assign err_cnt_o   = r_err_cnt;
    assign per_valid_o = !w_empty;
    assign per_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign per_ovf_o   = r_ovf;

endmodule

// File: tb/tb_cnt_wrap_monitor.sv
// Bench for cnt_wrap_monitor: an up-counting and a down-counting instance share one stimulus
// stream (the down instance sees the bitwise complement), each checked against a timestamp-based model.
module tb_cnt_wrap_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ready;
    logic [7:0]  cnt_up;
    logic [7:0]  cnt_dn;

    logic        up_wrap, up_err, up_valid, up_ovf;
    logic [7:0]  up_ecnt;
    logic [15:0] up_data;
    logic        dn_wrap, dn_err, dn_valid, dn_ovf;
    logic [7:0]  dn_ecnt;
    logic [15:0] dn_data;

    always #5 clk = ~clk;
    assign cnt_dn = ~cnt_up;

    cnt_wrap_monitor #(.CW(8), .INC_DEC(1), .FIFO_DEPTH(4), .PW(16)) u_up (
        .clk(clk), .rst(rst), .en_i(en), .cnt_i(cnt_up),
        .wrap_o(up_wrap), .err_o(up_err), .err_cnt_o(up_ecnt),
        .per_data_o(up_data), .per_valid_o(up_valid), .per_ready_i(ready), .per_ovf_o(up_ovf)
    );

    cnt_wrap_monitor #(.CW(8), .INC_DEC(0), .FIFO_DEPTH(4), .PW(16)) u_dn (
        .clk(clk), .rst(rst), .en_i(en), .cnt_i(cnt_dn),
        .wrap_o(dn_wrap), .err_o(dn_err), .err_cnt_o(dn_ecnt),
        .per_data_o(dn_data), .per_valid_o(dn_valid), .per_ready_i(ready), .per_ovf_o(dn_ovf)
    );

`ifdef CNT_MON_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: index 0 = up instance, 1 = down instance. Periods come from edge timestamps.
    int m_st    [2];
    int m_prev  [2];
    bit m_armed [2];
    int m_last  [2];
    int m_fifo  [2][4];
    int m_fcnt  [2];
    bit m_wrap  [2];
    bit m_err   [2];
    bit m_ovf   [2];
    int m_ecnt  [2];
    int cyc = 0;

    int wrap_n;
    bit wv [8];
    int wd [8];
    int v;

    typedef struct {
        bit r;
        bit e;
        int c;
        bit rd;
        bit x_wrap;
        bit x_err;
        int x_ecnt;
        bit x_valid;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit e, input int c, input bit rd);
        bit pop;
        bit full;
        bit wrap;
        bit push;
        int val;
        int expv;
        bit up;
        up = (i == 0);
        if (r) begin
            m_st[i] = 0; m_prev[i] = 0; m_armed[i] = 0; m_last[i] = 0; m_fcnt[i] = 0;
            m_wrap[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_ecnt[i] = 0;
            return;
        end
        pop  = (m_fcnt[i] > 0) && rd;
        full = (m_fcnt[i] == 4);
        wrap = 0;
        push = 0;
        val  = 0;
        if (!e) begin
            m_st[i] = 0;
            m_armed[i] = 0;
        end else if (m_st[i] == 0) begin
            m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            m_prev[i] = c;
            m_st[i] = 2;
        end else if (!(HOLD && c == m_prev[i])) begin
            expv = up ? (m_prev[i] + 1) % 256 : (m_prev[i] + 255) % 256;
            if (c == expv) begin
                wrap = up ? (m_prev[i] == 255) : (m_prev[i] == 0);
                m_prev[i] = c;
                if (wrap) begin
                    if (m_armed[i]) begin
                        push = 1;
                        val = cyc - m_last[i];
                        if (val > 65535) val = 65535;
                    end
                    m_armed[i] = 1;
                    m_last[i] = cyc;
                end
            end else begin
                m_err[i] = 1;
                if (m_ecnt[i] < 255) m_ecnt[i]++;
                m_armed[i] = 0;
                m_st[i] = 1;
            end
        end
        if (pop) begin
            for (int k = 0; k < 3; k++) m_fifo[i][k] = m_fifo[i][k+1];
            m_fcnt[i]--;
        end
        if (push) begin
            if (full && !pop) begin
                m_ovf[i] = 1;
            end else begin
                m_fifo[i][m_fcnt[i]] = val;
                m_fcnt[i]++;
            end
        end
        m_wrap[i] = wrap;
    endtask

    function automatic int m_head(input int i);
        return (m_fcnt[i] > 0) ? m_fifo[i][0] : 0;
    endfunction

    // One clock: drive, let the edge happen, advance the model, compare 1 ns later.
    task automatic cycle(input bit r, input bit e, input int c, input bit rd);
        rst = r; en = e; cnt_up = 8'(c); ready = rd;
        @(posedge clk);
        cyc++;
        model_edge(0, r, e, c & 255, rd);
        model_edge(1, r, e, 255 - (c & 255), rd);
        #1;
        chk("up_wrap",  int'(up_wrap),  int'(m_wrap[0]));
        chk("up_err",   int'(up_err),   int'(m_err[0]));
        chk("up_ecnt",  int'(up_ecnt),  m_ecnt[0]);
        chk("up_valid", int'(up_valid), int'(m_fcnt[0] > 0));
        chk("up_data",  int'(up_data),  m_head(0));
        chk("up_ovf",   int'(up_ovf),   int'(m_ovf[0]));
        chk("dn_wrap",  int'(dn_wrap),  int'(m_wrap[1]));
        chk("dn_err",   int'(dn_err),   int'(m_err[1]));
        chk("dn_ecnt",  int'(dn_ecnt),  m_ecnt[1]);
        chk("dn_valid", int'(dn_valid), int'(m_fcnt[1] > 0));
        chk("dn_data",  int'(dn_data),  m_head(1));
        chk("dn_ovf",   int'(dn_ovf),   int'(m_ovf[1]));
        if (up_wrap) begin
            wrap_n++;
            if (wrap_n < 8) begin
                wv[wrap_n] = up_valid;
                wd[wrap_n] = int'(up_data);
            end
        end
    endtask

    task automatic feed(input int n, input bit rd);
        repeat (n) begin
            cycle(1'b0, 1'b1, v, rd);
            v++;
        end
    endtask

    task automatic restart();
        cycle(1'b1, 1'b0, 0, 1'b1);
        wrap_n = 0;
        v = 0;
        for (int k = 0; k < 8; k++) begin
            wv[k] = 0;
            wd[k] = 0;
        end
    endtask

    initial begin
        int pops;
        int off;
        int u;
        bit rd;
        bit r;
        rst = 1'b1; en = 1'b0; cnt_up = 8'd0; ready = 1'b1;

        // Startup, first (unarmed) wrap, step errors, disable, reset.
        tbl[0]  = '{1, 0,   0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 250, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 251, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 252, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 253, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 254, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 255, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 1,   0, 1, 1, 0, 0, 0};
        tbl[8]  = '{0, 1,   1, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1,   5, 1, 0, 1, 1, 0};
        tbl[10] = '{0, 1,   6, 1, 0, 1, 1, 0};
        tbl[11] = '{0, 1,   7, 1, 0, 1, 1, 0};
        tbl[12] = '{0, 1,   9, 1, 0, 1, 2, 0};
        tbl[13] = '{0, 0,  10, 1, 0, 1, 2, 0};
        tbl[14] = '{1, 0,   0, 1, 0, 0, 0, 0};
        for (int k = 0; k < 15; k++) begin
            cycle(tbl[k].r, tbl[k].e, tbl[k].c, tbl[k].rd);
            chk($sformatf("tbl%0d_wrap", k),  int'(up_wrap),  int'(tbl[k].x_wrap));
            chk($sformatf("tbl%0d_err", k),   int'(up_err),   int'(tbl[k].x_err));
            chk($sformatf("tbl%0d_ecnt", k),  int'(up_ecnt),  tbl[k].x_ecnt);
            chk($sformatf("tbl%0d_valid", k), int'(up_valid), int'(tbl[k].x_valid));
        end

        // Free-running count: wraps every 256 clocks, periods of 256 from the second wrap.
        restart();
        feed(780, 1'b1);
        chk("t1_wraps", wrap_n, 3);
        chk("t1_w1_valid", int'(wv[1]), 0);
        chk("t1_w2_valid", int'(wv[2]), 1);
        chk("t1_w2_data", wd[2], 256);
        chk("t1_w3_data", wd[3], 256);
        chk("t1_up_ecnt", int'(up_ecnt), 0);
        chk("t1_dn_ecnt", int'(dn_ecnt), 0);
        chk("t1_ovf", int'(up_ovf | dn_ovf), 0);

        // Jump 10 -> 20: error, re-arm on the next wrap, push on the one after.
        restart();
        feed(11, 1'b1);
        cycle(1'b0, 1'b1, 20, 1'b1);
        chk("t3_err", int'(up_err), 1);
        chk("t3_ecnt", int'(up_ecnt), 1);
        v = 21;
        feed(515 - 21, 1'b1);
        chk("t3_wraps", wrap_n, 2);
        chk("t3_w1_valid", int'(wv[1]), 0);
        chk("t3_w2_valid", int'(wv[2]), 1);
        chk("t3_w2_data", wd[2], 256);

        // Consumer stalled over 6 wraps: FIFO fills, one period dropped, then drains.
        restart();
        feed(1540, 1'b0);
        chk("t4_wraps", wrap_n, 6);
        chk("t4_valid", int'(up_valid), 1);
        chk("t4_head", int'(up_data), 256);
        chk("t4_head_w6", wd[6], 256);
        chk("t4_ovf", int'(up_ovf), 1);
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            if (up_valid) pops++;
            cycle(1'b0, 1'b1, v, 1'b1);
            v++;
        end
        chk("t4_pops", pops, 4);
        chk("t4_empty", int'(up_valid), 0);
        chk("t4_ovf_kept", int'(up_ovf), 1);

        // Reset with two queued periods and a sticky error.
        restart();
        feed(11, 1'b0);
        cycle(1'b0, 1'b1, 50, 1'b0);
        v = 51;
        feed(770 - 51, 1'b0);
        chk("t5_pre_valid", int'(up_valid), 1);
        chk("t5_pre_err", int'(up_err), 1);
        cycle(1'b1, 1'b1, v, 1'b0);
        chk("t5_valid", int'(up_valid | dn_valid), 0);
        chk("t5_data", int'(up_data), 0);
        chk("t5_err", int'(up_err | dn_err), 0);
        chk("t5_ecnt", int'(up_ecnt), 0);
        feed(4, 1'b1);
        chk("t5_resync_err", int'(up_err), 0);

        // Counter holds one value for 3 extra clocks.
        restart();
        feed(300, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 300, 1'b1);
        v = 301;
        feed(515 - 301, 1'b1);
        chk("t6_wraps", wrap_n, 2);
        if (HOLD) begin
            chk("t6_ecnt", int'(up_ecnt), 0);
            chk("t6_w2_valid", int'(wv[2]), 1);
            chk("t6_w2_data", wd[2], 259);
        end else begin
            chk("t6_ecnt", int'(up_ecnt), 2);
            chk("t6_w2_valid", int'(wv[2]), 0);
        end

        // Error counter saturation: every TRACK cycle is a +7 step.
        restart();
        for (int k = 0; k < 600; k++) cycle(1'b0, 1'b1, (k * 7) & 255, 1'b1);
        chk("sat_up_ecnt", int'(up_ecnt), 255);
        chk("sat_dn_ecnt", int'(dn_ecnt), 255);

        // Randomized: mostly clean counting with jumps, holds, disables, resets, random ready.
        restart();
        v = int'($urandom_range(0, 255));
        off = 0;
        for (int k = 0; k < 4000; k++) begin
            u = int'($urandom_range(0, 299));
            if (u == 0) v = int'($urandom_range(0, 255));
            else if (u >= 3) v = (v + 1) & 255;
            if (off == 0 && $urandom_range(0, 399) == 0) off = int'($urandom_range(1, 5));
            rd = ((k / 1000) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 1999) == 0);
            cycle(r, off == 0, v, rd);
            if (off > 0) off--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
